cd_host_link: RTL and testbench

// - Host-side end of the CDD nibble link: answers drive CD_nIRQ, clocks in 10 status nibbles, clocks out 10 command nibbles.
// - Drives HOCK, follows CDCK. Sits between the CD system registers and the CDD MCU model running at a 250 kHz tick.
// - Presents each status frame to the register file and takes the next command frame from it.

---
 rtl/cd_host_link.sv | 164 ++++++++++++++++
 tb/tb_cd_host_link.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cd_host_link.sv
// cd_host_link: host end of the CDD nibble link; define CDD_CHECKSUM_EN to generate/check frame checksums
module cd_host_link #(
   parameter int HOLD_CYCLES = 128,
   parameter int TIMEOUT = 8191
) (
   input  logic        CLK_12M,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic        CD_nIRQ,
   input  logic        CDCK,
   input  logic [3:0]  CDD_DOUT,
   output logic        HOCK,
   output logic [3:0]  CDD_DIN,
   input  logic [39:0] CMD_DATA,
   output logic [39:0] STATUS_DATA,
   output logic        STATUS_STB,
   output logic        STATUS_OK,
   output logic        COMM_ERR,
   output logic        BUSY
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, S_LO, S_HI, C_LO, C_HI, C_WAIT} state_t;
   state_t state_q, state_d;
   logic [2:0] irq_q;
   logic [1:0] cdck_q;
   logic [3:0] dout_m_q, dout_s_q;
   logic [3:0] n_q, n_d;
   logic hock_q, hock_d, pend_q, pend_d, stb_q, stb_d, ok_q, ok_d, err_q, err_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [12:0] wait_q, wait_d;
   logic [39:0] cmd_q, cmd_d, stat_q, stat_d, status_q, status_d;
   logic irq_fall, hold_ok, cdck_s;
`ifdef CDD_CHECKSUM_EN
   function automatic logic [3:0] csum(input logic [35:0] f);
      logic [3:0] s;
      s = 4'd5;
      for (int i = 0; i < 9; i++) s = s + f[4*i +: 4];
      return ~s;
   endfunction
`endif
   assign irq_fall = irq_q[2] & ~irq_q[1];
   assign cdck_s = cdck_q[1];
   assign hold_ok = hold_q >= HW'(HOLD_CYCLES);
   always_comb begin
      state_d = state_q;
      n_d = n_q;
      hock_d = hock_q;
      pend_d = pend_q;
      cmd_d = cmd_q;
      stat_d = stat_q;
      status_d = status_q;
      ok_d = ok_q;
      stb_d = 1'b0;
      err_d = 1'b0;
      case (state_q)
         IDLE: begin
            pend_d = pend_q | (irq_fall & ENABLE);
            if (!hock_q && hold_ok) hock_d = 1'b1;
            else if (hock_q && hold_ok && pend_d) begin
`ifdef CDD_CHECKSUM_EN
               cmd_d = {csum(CMD_DATA[35:0]), CMD_DATA[35:0]};
`else
               cmd_d = CMD_DATA;
`endif
               pend_d = 1'b0;
               n_d = 4'd0;
               hock_d = 1'b0;
               state_d = S_LO;
            end
         end
         S_LO: if (!cdck_s && hold_ok) begin
            stat_d[4*n_q +: 4] = dout_s_q;
            hock_d = 1'b1;
            state_d = S_HI;
         end
         S_HI: if (cdck_s && hold_ok) begin
            hock_d = 1'b0;
            if (n_q != 4'd9) begin
               n_d = n_q + 4'd1;
               state_d = S_LO;
            end else begin
               status_d = stat_q;
`ifdef CDD_CHECKSUM_EN
               ok_d = stat_q[39:36] == csum(stat_q[35:0]);
`else
               ok_d = 1'b1;
`endif
               stb_d = 1'b1;
               n_d = 4'd0;
               state_d = C_LO;
            end
         end
         C_LO: if (hold_ok) begin
            hock_d = 1'b1;
            state_d = C_HI;
         end
         C_HI: if (cdck_s && hold_ok) begin
            hock_d = 1'b0;
            state_d = C_WAIT;
         end
         C_WAIT: if (!cdck_s) begin
            n_d = (n_q != 4'd9) ? n_q + 4'd1 : 4'd0;
            state_d = (n_q != 4'd9) ? C_LO : IDLE;
         end
         default: state_d = IDLE;
      endcase
      // a timeout or a fresh IRQ mid-frame drops the frame; a restart re-acks from IDLE
      if (state_q != IDLE && (irq_fall || wait_q == 13'(TIMEOUT))) begin
         err_d = 1'b1;
         hock_d = 1'b1;
         pend_d = irq_fall & ENABLE;
         status_d = status_q;
         ok_d = ok_q;
         stb_d = 1'b0;
         state_d = IDLE;
      end
      wait_d = (state_q == IDLE || state_d != state_q) ? 13'd0 : wait_q + 13'd1;
      hold_d = (hock_d != hock_q) ? '0 : hold_ok ? hold_q : hold_q + 1'b1;
   end
   always_ff @(posedge CLK_12M or posedge RESET) begin
      if (RESET) begin
         irq_q <= 3'b111;
         cdck_q <= 2'b11;
         dout_m_q <= 4'd0;
         dout_s_q <= 4'd0;
         state_q <= IDLE;
         n_q <= 4'd0;
         hock_q <= 1'b1;
         pend_q <= 1'b0;
         hold_q <= '0;
         wait_q <= 13'd0;
         cmd_q <= 40'd0;
         stat_q <= 40'd0;
         status_q <= 40'd0;
         ok_q <= 1'b0;
         stb_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         irq_q <= {irq_q[1:0], CD_nIRQ};
         cdck_q <= {cdck_q[0], CDCK};
         dout_m_q <= CDD_DOUT;
         dout_s_q <= dout_m_q;
         state_q <= state_d;
         n_q <= n_d;
         hock_q <= hock_d;
         pend_q <= pend_d;
         hold_q <= hold_d;
         wait_q <= wait_d;
         cmd_q <= cmd_d;
         stat_q <= stat_d;
         status_q <= status_d;
         ok_q <= ok_d;
         stb_q <= stb_d;
         err_q <= err_d;
      end
   end
   assign HOCK = hock_q;
   assign CDD_DIN = (state_q inside {C_LO, C_HI, C_WAIT}) ? cmd_q[4*n_q +: 4] : 4'd0;
   assign STATUS_DATA = status_q;
   assign STATUS_STB = stb_q;
   assign STATUS_OK = ok_q;
   assign COMM_ERR = err_q;
   assign BUSY = (state_q != IDLE) | pend_q;
endmodule

// File: tb/tb_cd_host_link.sv
// tb_cd_host_link: drive-side BFM with a scoreboard of expected status/command frames and errors
`timescale 1ns/1ps
module tb_cd_host_link;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b1, nirq = 1'b1, cdck = 1'b1;
   logic [3:0] dout = 4'd0;
   logic [39:0] cmd = 40'd0;
   logic hock, stb, ok, err, busy;
   logic [3:0] din;
   logic [39:0] status;
   int tests = 0, fails = 0, stb_cnt = 0, err_cnt = 0, exp_err = 0;
   logic [40:0] exp_stat[$];
   logic [39:0] exp_cmd[$];
   logic [40:0] e_stat;
   logic [39:0] rx;
   event rx_ev;
`ifdef CDD_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   cd_host_link dut (
      .CLK_12M(clk), .RESET(rst), .ENABLE(enable), .CD_nIRQ(nirq), .CDCK(cdck),
      .CDD_DOUT(dout), .HOCK(hock), .CDD_DIN(din), .CMD_DATA(cmd),
      .STATUS_DATA(status), .STATUS_STB(stb), .STATUS_OK(ok), .COMM_ERR(err), .BUSY(busy)
   );
   always #42 clk = ~clk;
   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (stb) begin
         stb_cnt++;
         check("stb_expected", exp_stat.size() != 0, 1);
         if (exp_stat.size() != 0) begin
            e_stat = exp_stat.pop_front();
            check("status_data", status, e_stat[39:0]);
            check("status_ok", ok, e_stat[40]);
         end
      end
      if (err) begin
         err_cnt++;
         check("comm_err_expected", exp_err > 0, 1);
         if (exp_err > 0) exp_err--;
      end
   end
   always @(rx_ev) begin
      check("cmd_expected", exp_cmd.size() != 0, 1);
      if (exp_cmd.size() != 0) check("cmd_frame", rx, exp_cmd.pop_front());
   end
   task automatic tick_wait(input logic lvl);
      bit got = 1'b0;
      for (int t = 0; t < 400 && !got; t++) begin
         repeat (48) @(negedge clk);
         got = (hock == lvl);
      end
      check("hock_wait", got, 1);
   endtask
   task automatic frame(input logic [39:0] s, input int stop_nib, input int freeze_nib,
                        input int dis_nib, input int abort_nib);
      logic [39:0] r = 40'd0;
      nirq = 1'b0;
      tick_wait(1'b0);
      nirq = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == stop_nib) return;
         if (i == dis_nib) enable = 1'b0;
         dout = s[4*i +: 4];
         cdck = 1'b0;
         tick_wait(1'b1);
         if (i == freeze_nib) return;
         cdck = 1'b1;
         tick_wait(1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         if (i == abort_nib) begin
            nirq = 1'b0;
            cdck = 1'b1;
            tick_wait(1'b1);
            return;
         end
         tick_wait(1'b1);
         r[4*i +: 4] = din;
         cdck = 1'b1;
         tick_wait(1'b0);
         cdck = 1'b0;
      end
      tick_wait(1'b1);
      rx = r;
      -> rx_ev;
   endtask
   task automatic check_reset_values(input string tag);
      check({tag, "_hock"}, hock, 1);
      check({tag, "_din"}, din, 0);
      check({tag, "_status"}, status, 0);
      check({tag, "_stb"}, stb, 0);
      check({tag, "_ok"}, ok, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_busy"}, busy, 0);
   endtask
   initial begin
      repeat (90000) @(negedge clk);
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int e0;
      bit low_seen;
      repeat (4) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);
      cmd = 40'hF000004002;
      exp_stat.push_back({!CK, 40'h0123456789});
      exp_cmd.push_back(CK ? 40'h4000004002 : 40'hF000004002);
      frame(40'h0123456789, -1, -1, -1, -1);
      check("busy_after_frame", busy, 0);
      check("stb_count_1", stb_cnt, 1);
      cmd = 40'h9876543210;
      exp_stat.push_back({!CK, 40'h2111111111});
      exp_cmd.push_back(CK ? 40'h6876543210 : 40'h9876543210);
      frame(40'h2111111111, -1, -1, -1, -1);
      cmd = 40'h0000000000;
      exp_stat.push_back({1'b1, 40'h1111111111});
      exp_cmd.push_back(CK ? 40'hA000000000 : 40'h0000000000);
      frame(40'h1111111111, -1, -1, 2, -1);
      check("busy_after_disable", busy, 0);
      low_seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         nirq = 1'b0;
         repeat (100) @(negedge clk) low_seen |= !hock;
         nirq = 1'b1;
         repeat (100) @(negedge clk) low_seen |= !hock;
      end
      check("disabled_hock_low", low_seen, 0);
      check("disabled_busy", busy, 0);
      check("stb_count_3", stb_cnt, 3);
      enable = 1'b1;
      e0 = err_cnt;
      exp_err = 1;
      cmd = 40'h1234512345;
      frame(40'h0123456789, -1, 3, -1, -1);
      for (int t = 0; t < 10000 && err_cnt == e0; t++) @(negedge clk);
      check("timeout_err", err_cnt, e0 + 1);
      check("timeout_hock", hock, 1);
      check("timeout_busy", busy, 0);
      check("timeout_status_kept", status, 40'h1111111111);
      cdck = 1'b1;
      repeat (20) @(negedge clk);
      e0 = err_cnt;
      exp_err = 1;
      cmd = 40'h5555555555;
      exp_stat.push_back({1'b1, 40'h1111111111});
      frame(40'h1111111111, -1, -1, -1, 5);
      cmd = 40'h0FEDCBA987;
      check("abort_err", err_cnt, e0 + 1);
      exp_stat.push_back({!CK, 40'h0123456789});
      exp_cmd.push_back(CK ? 40'h7FEDCBA987 : 40'h0FEDCBA987);
      frame(40'h0123456789, -1, -1, -1, -1);
      check("restart_busy", busy, 0);
      check("stb_count_5", stb_cnt, 5);
      frame(40'h1111111111, 3, -1, -1, -1);
      check("midframe_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("midreset");
      rst = 1'b0;
      nirq = 1'b1;
      cdck = 1'b1;
      repeat (300) @(negedge clk);
      check("end_stat_queue", exp_stat.size(), 0);
      check("end_cmd_queue", exp_cmd.size(), 0);
      check("end_err_pending", exp_err, 0);
      check("end_stb_count", stb_cnt, 5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
